// File: rtl/bus_ram_responder.sv
// ---------------------------------------------------------------------------
// bus_ram_responder
//
// Single-port 32-bit word RAM behind a simple request/acknowledge bus.
// A request is captured in IDLE, optionally held for WAIT_CYCLES cycles,
// then completed with a one-cycle o_ack pulse. Writes honour byte lanes;
// reads return the addressed word only during the ack cycle.
//
// Parameters
//   BASE_ADDR   : byte address of word 0
//   WORDS       : memory depth in 32-bit words (power of two, 2..65536)
//   WAIT_CYCLES : extra cycles between capture and ack (0..15)
//
// Ports
//   i_clk       : clock, all state changes on the rising edge
//   i_rst       : asynchronous active-high reset
//   i_bus_en    : transaction request (sampled only in IDLE)
//   i_wr_en     : 1 = write, 0 = read
//   i_addr      : byte address (bits 1:0 ignored)
//   i_wr_data   : write data
//   i_byte_en   : byte-lane write enables, bit n -> bits 8n+7:8n
//   o_ack       : one-cycle completion pulse
//   o_rd_data   : read data, zero whenever o_ack is low
//
// Optional feature
//   BUS_RAM_BOUNDS_CHECK_EN : when defined, accesses whose offset from
//   BASE_ADDR is at or beyond 4*WORDS are acked normally but write nothing
//   and read zero. When undefined, such addresses alias modulo WORDS.
// ---------------------------------------------------------------------------
module bus_ram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WORDS       = 1024,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bus_en,
    input  logic        i_wr_en,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wr_data,
    input  logic [3:0]  i_byte_en,
    output logic        o_ack,
    output logic [31:0] o_rd_data
);

    localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;

    logic        r_req_wr;
    logic [31:0] r_req_addr;
    logic [31:0] r_req_wdata;
    logic [3:0]  r_req_be;

    logic [31:0] r_rd_data;
    logic [31:0] r_mem [WORDS];

    logic        w_wr;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [31:0] w_off;
    logic [AW-1:0] w_idx;
    logic        w_in_range;
    logic        w_enter_ack;

    // With WAIT_CYCLES=0 the capture edge is also the edge entering ACK,
    // so the access must use the live inputs while still in IDLE.
    always_comb begin
        w_wr    = r_req_wr;
        w_addr  = r_req_addr;
        w_wdata = r_req_wdata;
        w_be    = r_req_be;
        if (r_state == S_IDLE) begin
            w_wr    = i_wr_en;
            w_addr  = i_addr;
            w_wdata = i_wr_data;
            w_be    = i_byte_en;
        end
    end

    assign w_off = w_addr - BASE_ADDR;
    assign w_idx = AW'(w_off >> 2);

`ifdef BUS_RAM_BOUNDS_CHECK_EN
    assign w_in_range = (w_off < 32'(4 * WORDS));
`else
    assign w_in_range = 1'b1;
`endif

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_bus_en) begin
                    w_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_ACK;
                end
            end
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Gated by reset so an edge arriving while reset is held never commits.
    assign w_enter_ack = (w_next == S_ACK) && !i_rst;

    // State, wait counter and read-data register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_rd_data <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_next == S_WAIT) begin
                r_cnt <= 4'(WAIT_CYCLES - 1);
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Loaded only for an in-range read entering ACK; every other
            // edge clears it so the output is zero outside the ack cycle.
            if (w_enter_ack && !w_wr && w_in_range) begin
                r_rd_data <= r_mem[w_idx];
            end else begin
                r_rd_data <= 32'd0;
            end
        end
    end

    // Request capture
    always_ff @(posedge i_clk) begin
        if (r_state == S_IDLE && i_bus_en) begin
            r_req_wr    <= i_wr_en;
            r_req_addr  <= i_addr;
            r_req_wdata <= i_wr_data;
            r_req_be    <= i_byte_en;
        end
    end

    // Memory array, intentionally not reset
    always_ff @(posedge i_clk) begin
        if (w_enter_ack && w_wr && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_ack     = (r_state == S_ACK);
    assign o_rd_data = r_rd_data;

endmodule

// File: tb/tb_bus_ram_responder.sv
// ---------------------------------------------------------------------------
// tb_bus_ram_responder
//
// Directed and randomized bench for bus_ram_responder. A word-array model
// predicts read data and ack timing from the behavioural rules: one ack
// WAIT_CYCLES+1 cycles after the request is taken, byte-lane merges on
// write, optional out-of-range suppression under BUS_RAM_BOUNDS_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_bus_ram_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          WORDS = 1024;
    localparam int          W     = 3;
`ifdef BUS_RAM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [3:0]  byte_en;
    logic        ack;
    logic [31:0] rd_data;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] m_mem [WORDS];
    bit          m_vld [WORDS];

    always #5 clk = ~clk;

    bus_ram_responder #(
        .BASE_ADDR  (BASE),
        .WORDS      (WORDS),
        .WAIT_CYCLES(W)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_bus_en (bus_en),
        .i_wr_en  (wr_en),
        .i_addr   (addr),
        .i_wr_data(wr_data),
        .i_byte_en(byte_en),
        .o_ack    (ack),
        .o_rd_data(rd_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_in(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return BC ? (off < 32'(4 * WORDS)) : 1'b1;
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off / 4) % WORDS);
    endfunction

    // One complete transaction; rd returns the data seen in the ack cycle.
    task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] rd);
        logic [31:0] exp;
        bit          known;
        int          idx;
        idx   = m_idx(a);
        known = wr || !m_in(a) || m_vld[idx];
        exp   = (!wr && m_in(a)) ? m_mem[idx] : 32'd0;
        rd    = 32'd0;
        @(negedge clk);
        wr_en = wr; addr = a; wr_data = d; byte_en = be; bus_en = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= W + 1; k++) begin
            @(negedge clk);
            check("ack_timing", {31'd0, ack}, {31'd0, k == W});
            if (k == W) begin
                rd = rd_data;
                if (known) check("rd_data", rd_data, exp);
            end else begin
                check("rd_zero", rd_data, 32'd0);
            end
            if (k <= W) begin
                // Inputs are ignored after capture; scramble them.
                bus_en  = 1'($urandom);
                wr_en   = 1'($urandom);
                addr    = $urandom;
                wr_data = $urandom;
                byte_en = 4'($urandom);
            end else begin
                bus_en = 1'b0;
            end
        end
        if (wr && m_in(a)) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) m_mem[idx][8*b +: 8] = d[8*b +: 8];
            if (be == 4'hF) m_vld[idx] = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        bit          wr;
        for (int i = 0; i < WORDS; i++) begin
            m_mem[i] = 32'd0;
            m_vld[i] = 1'b0;
        end
        rst = 1'b1; bus_en = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0; byte_en = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_rd", rd_data, 32'd0);
        rst = 1'b0;

        // Full-word write then read back
        txn(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, rd);
        txn(1'b0, BASE + 32'h10, 32'h0, 4'h0, rd);
        check("wr_rd_const", rd, 32'hDEAD_BEEF);

        // Byte-lane merge
        txn(1'b1, BASE + 32'h20, 32'h1122_3344, 4'hF, rd);
        txn(1'b1, BASE + 32'h20, 32'hAABB_CCDD, 4'b0101, rd);
        check("wr_ack_rd_zero", rd, 32'd0);
        txn(1'b0, BASE + 32'h23, 32'h0, 4'h0, rd);
        check("lane_merge", rd, 32'h11BB_33DD);

        // byte_en=0 changes nothing
        txn(1'b1, BASE + 32'h20, 32'h5555_5555, 4'h0, rd);
        txn(1'b0, BASE + 32'h20, 32'h0, 4'h0, rd);
        check("be_zero", rd, 32'h11BB_33DD);

        // Out-of-range access: suppressed or aliased to word 0
        txn(1'b1, BASE, 32'h0BAD_F00D, 4'hF, rd);
        txn(1'b1, BASE + 32'h1000, 32'hCAFE_F00D, 4'hF, rd);
        txn(1'b0, BASE + 32'h1000, 32'h0, 4'h0, rd);
        check("oor_read", rd, BC ? 32'h0 : 32'hCAFE_F00D);
        txn(1'b0, BASE, 32'h0, 4'h0, rd);
        check("word0_after_oor", rd, BC ? 32'h0BAD_F00D : 32'hCAFE_F00D);

        // Seed a small window, then randomized traffic
        for (int i = 0; i < 16; i++)
            txn(1'b1, BASE + 32'(4 * i), $urandom, 4'hF, rd);
        for (int n = 0; n < 150; n++) begin
            a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: a = a + 32'h1000;
                1: a = BASE - 32'd4;
                default: ;
            endcase
            wr = 1'($urandom);
            txn(wr, a, $urandom, 4'($urandom), rd);
        end

        // Request held high through ack: exactly one ack per transaction,
        // second one taken in the IDLE cycle right after the first ack.
        a = BASE + 32'h10;
        @(negedge clk);
        wr_en = 1'b0; addr = a; byte_en = 4'h0; bus_en = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 2 * W + 3; k++) begin
            @(negedge clk);
            check("b2b_ack", {31'd0, ack}, {31'd0, (k == W) || (k == 2 * W + 2)});
            check("b2b_rd", rd_data, ack ? m_mem[m_idx(a)] : 32'd0);
            if (k == 2 * W + 2) bus_en = 1'b0;
        end

        // Reset during WAIT of a write aborts it
        a = BASE + 32'h24;
        @(negedge clk);
        wr_en = 1'b1; addr = a; wr_data = 32'h1234_5678; byte_en = 4'hF; bus_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_en = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_ack", {31'd0, ack}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < W + 3; k++) begin
            @(negedge clk);
            check("abort_no_ack", {31'd0, ack}, 32'd0);
        end
        txn(1'b0, a, 32'h0, 4'h0, rd);

        // Asynchronous reset in the middle of a read ack
        @(negedge clk);
        wr_en = 1'b0; addr = BASE + 32'h10; bus_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_en = 1'b0;
        repeat (W) @(negedge clk);
        check("pre_rst_ack", {31'd0, ack}, 32'd1);
        check("pre_rst_rd", rd_data, m_mem[m_idx(BASE + 32'h10)]);
        #2 rst = 1'b1;
        #1;
        check("async_rst_ack", {31'd0, ack}, 32'd0);
        check("async_rst_rd", rd_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        txn(1'b0, BASE + 32'h10, 32'h0, 4'h0, rd);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
